arinc708_manchester_tx: RTL and testbench

ARINC 708 weather-radar bus transmitter core. It accepts a frame of fifty 32-bit words from the FIFO-fed TX controller over a valid/ready stream and serialises them as one 1600-bit Manchester II bi-phase word at 1 Mbit/s, preceded by a 3-bit-time sync. It drives the differential line-driver pair A/B plus the driver inhibit. It reports frame activity and completion back to the controller, which raises the interrupt flag.

---
 rtl/arinc708_pkg.sv | 8 +
 rtl/arinc708_bit_timer.sv | 16 +
 rtl/arinc708_manchester_tx.sv | 142 ++++++++++++++
 tb/tb_arinc708_manchester_tx.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/arinc708_pkg.sv
// arinc708_pkg: frame geometry constants and transmitter state type for the ARINC 708 TX core.
package arinc708_pkg;
  localparam int WORDS_PER_FRAME = 50;
  localparam int BITS_PER_WORD   = 32;
  localparam int SYNC_HALF_BITS  = 6;
  localparam int GAP_BITS        = 4;
  typedef enum logic [1:0] {IDLE, SYNC, DATA, GAP} tx_state_t;
endpackage

// File: rtl/arinc708_bit_timer.sv
// arinc708_bit_timer: free-running half-bit tick generator, realigned at frame start.
module arinc708_bit_timer #(
  parameter int HALF = 25
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  output logic tick
);
  localparam int W = $clog2(HALF);
  logic [W-1:0] cnt;
  assign tick = cnt == W'(HALF - 1);
  always_ff @(posedge clk or negedge reset)
    if (!reset) cnt <= '0;
    else cnt <= (clr || tick) ? '0 : cnt + W'(1);
endmodule

// File: rtl/arinc708_manchester_tx.sv
// arinc708_manchester_tx: ARINC 708 frame serialiser, sync + 1600 Manchester II bits on A/B.
module arinc708_manchester_tx
  import arinc708_pkg::*;
#(
  parameter int IN_AVS_CLK = 50_000_000,
  parameter int BIT_RATE   = 1_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_sink_tx_valid,
  input  logic [31:0] i_sink_tx_data,
  output logic        o_sink_tx_ready,
  input  logic        i_arinc708_tx_en,
  output logic        o_arinc708_tx_active,
  output logic        o_arinc708_tx_compl_pe,
  output logic        o_arinc708_tx_underrun,
  output logic        o_arinc708_tx_A,
  output logic        o_arinc708_tx_B,
  output logic        o_arinc708_tx_Off
);
  localparam int HALF = IN_AVS_CLK / (2 * BIT_RATE);
  if (HALF < 2 || HALF * 2 * BIT_RATE != IN_AVS_CLK) begin : g_bad_rate
    $error("IN_AVS_CLK/(2*BIT_RATE) must be an integer >= 2");
  end
  tx_state_t   state, state_n;
  logic [2:0]  half, half_n;
  logic [4:0]  bit_cnt, bit_cnt_n;
  logic [5:0]  word_cnt, word_cnt_n;
  logic [31:0] shift, shift_n, hold, hold_n;
  logic        hold_full, hold_full_n;
  logic        a_n, b_n, off_n, active_n, compl_n, under_n;
  logic        tick, accept, start;
  assign o_sink_tx_ready = reset && i_arinc708_tx_en &&
    (state == IDLE || (state != GAP && !hold_full && word_cnt < 6'(WORDS_PER_FRAME)));
  assign accept = i_sink_tx_valid && o_sink_tx_ready;
  assign start  = accept && state == IDLE;
  arinc708_bit_timer #(.HALF(HALF)) u_timer (
    .clk  (clk),
    .reset(reset),
    .clr  (start),
    .tick (tick)
  );
  always_comb begin
    state_n     = state;
    half_n      = half;
    bit_cnt_n   = bit_cnt;
    word_cnt_n  = word_cnt;
    shift_n     = shift;
    hold_n      = hold;
    hold_full_n = hold_full;
    compl_n     = 1'b0;
    under_n     = 1'b0;
    if (state != IDLE && !i_arinc708_tx_en) begin
      state_n     = IDLE;
      half_n      = '0;
      bit_cnt_n   = '0;
      word_cnt_n  = '0;
      hold_full_n = 1'b0;
    end else begin
      if (start) begin
        state_n    = SYNC;
        shift_n    = i_sink_tx_data;
        word_cnt_n = 6'd1;
        bit_cnt_n  = '0;
        half_n     = '0;
      end else if (accept) begin
        hold_n      = i_sink_tx_data;
        hold_full_n = 1'b1;
      end
      // half counts sync half-bits, the phase within a data bit, or gap half-bits
      if (tick) begin
        case (state)
          SYNC: begin
            state_n = half == 3'(SYNC_HALF_BITS - 1) ? DATA : SYNC;
            half_n  = half == 3'(SYNC_HALF_BITS - 1) ? 3'd0 : half + 3'd1;
          end
          DATA:
            if (half == 3'd0) half_n = 3'd1;
            else begin
              half_n    = '0;
              shift_n   = shift >> 1;
              bit_cnt_n = bit_cnt + 5'd1;
              if (bit_cnt == 5'(BITS_PER_WORD - 1)) begin
                if (word_cnt == 6'(WORDS_PER_FRAME)) begin
                  state_n = GAP;
                  compl_n = 1'b1;
                end else if (hold_full) begin
                  shift_n     = hold;
                  hold_full_n = 1'b0;
                  word_cnt_n  = word_cnt + 6'd1;
                end else begin
                  state_n     = GAP;
                  under_n     = 1'b1;
                  hold_full_n = 1'b0;
                end
              end
            end
          GAP: begin
            state_n = half == 3'(2 * GAP_BITS - 1) ? IDLE : GAP;
            half_n  = half == 3'(2 * GAP_BITS - 1) ? 3'd0 : half + 3'd1;
          end
          default: ;
        endcase
      end
    end
    active_n = state_n == SYNC || state_n == DATA;
    off_n    = state_n == IDLE;
    a_n      = state_n == SYNC ? half_n < 3'(SYNC_HALF_BITS / 2) :
               state_n == DATA ? shift_n[0] ^ half_n[0] : 1'b0;
    b_n      = active_n && !a_n;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state                  <= IDLE;
      half                   <= '0;
      bit_cnt                <= '0;
      word_cnt               <= '0;
      shift                  <= '0;
      hold                   <= '0;
      hold_full              <= 1'b0;
      o_arinc708_tx_A        <= 1'b0;
      o_arinc708_tx_B        <= 1'b0;
      o_arinc708_tx_Off      <= 1'b1;
      o_arinc708_tx_active   <= 1'b0;
      o_arinc708_tx_compl_pe <= 1'b0;
      o_arinc708_tx_underrun <= 1'b0;
    end else begin
      state                  <= state_n;
      half                   <= half_n;
      bit_cnt                <= bit_cnt_n;
      word_cnt               <= word_cnt_n;
      shift                  <= shift_n;
      hold                   <= hold_n;
      hold_full              <= hold_full_n;
      o_arinc708_tx_A        <= a_n;
      o_arinc708_tx_B        <= b_n;
      o_arinc708_tx_Off      <= off_n;
      o_arinc708_tx_active   <= active_n;
      o_arinc708_tx_compl_pe <= compl_n;
      o_arinc708_tx_underrun <= under_n;
    end
endmodule

// File: tb/tb_arinc708_manchester_tx.sv
// tb_arinc708_manchester_tx: directed checks of frame timing, Manchester data, underrun, disable and reset.
module tb_arinc708_manchester_tx;
  localparam int H = 10;
  logic clk, reset, en, valid, ready, active, compl, under, a, b, off;
  logic [31:0] data;
  logic d50_en, d50_valid, d50_ready, d50_active, d50_compl, d50_under, d50_a, d50_b, d50_off;
  logic [31:0] d50_data;
  longint cyc = 0;
  int n_acc = 0, acc0 = 0, lim = 0;
  bit feed = 0, acc_now = 0;
  int n_compl = 0, n_under = 0, n_rdy = 0;
  longint compl_cyc = 0;
  int n_chk = 0, n_fail = 0;
  longint t0, s0, c1;
  bit ok;
  int na1, nb1, na2, nb2, bad, snap_c, snap_u, snap_r;
  logic s_a1, s_b1, s_a2, s_b2;
  logic [31:0] got;

  assign valid = feed && (n_acc - acc0 < lim);
  assign data  = 32'hA5A5_0000 + 32'(n_acc - acc0);
  assign d50_data = 32'h0000_0001;

  arinc708_manchester_tx #(.IN_AVS_CLK(20_000_000), .BIT_RATE(1_000_000)) dut (
    .clk(clk), .reset(reset), .i_sink_tx_valid(valid), .i_sink_tx_data(data),
    .o_sink_tx_ready(ready), .i_arinc708_tx_en(en), .o_arinc708_tx_active(active),
    .o_arinc708_tx_compl_pe(compl), .o_arinc708_tx_underrun(under),
    .o_arinc708_tx_A(a), .o_arinc708_tx_B(b), .o_arinc708_tx_Off(off));

  arinc708_manchester_tx dut_50 (
    .clk(clk), .reset(reset), .i_sink_tx_valid(d50_valid), .i_sink_tx_data(d50_data),
    .o_sink_tx_ready(d50_ready), .i_arinc708_tx_en(d50_en), .o_arinc708_tx_active(d50_active),
    .o_arinc708_tx_compl_pe(d50_compl), .o_arinc708_tx_underrun(d50_under),
    .o_arinc708_tx_A(d50_a), .o_arinc708_tx_B(d50_b), .o_arinc708_tx_Off(d50_off));

  initial clk = 0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (acc_now) n_acc <= n_acc + 1;
  end

  always @(negedge clk) begin
    acc_now <= valid && ready;
    if (ready) n_rdy <= n_rdy + 1;
    if (compl) begin
      n_compl   <= n_compl + 1;
      compl_cyc <= cyc;
    end
    if (under) n_under <= n_under + 1;
  end

  task automatic check(input string tag, input longint obs, input longint exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_until(input longint c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic find_start(output longint t, output bit found);
    found = 0;
    t = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (valid && ready) begin
        t = cyc;
        found = 1;
        break;
      end
    end
  endtask

  initial begin
    #1_500_000;
    $display("FAIL timeout: simulation did not reach the summary");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1; en = 1; d50_en = 0; d50_valid = 0;
    #2 reset = 0;
    @(negedge clk);
    check("reset_outputs", {ready, active, compl, under, a, b, off}, 7'b0000001);
    @(posedge clk); #1 reset = 1;
    @(negedge clk);
    check("idle_ready_en1", ready, 1);
    @(posedge clk); #1 en = 0;
    @(negedge clk);
    check("idle_ready_en0", ready, 0);
    @(posedge clk); #1 en = 1;

    // default-rate instance: sync shape and first two bits
    d50_en = 1; d50_valid = 1;
    ok = 0; t0 = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (d50_ready) begin t0 = cyc; ok = 1; break; end
    end
    check("d50_start", ok, 1);
    s0 = t0 + 1;
    na1 = 0; nb1 = 0; na2 = 0; nb2 = 0;
    for (int c = 0; c < 150; c++) begin
      wait_until(s0 + c);
      if (c < 75) begin na1 += int'(d50_a); nb1 += int'(d50_b); end
      else begin na2 += int'(d50_a); nb2 += int'(d50_b); end
    end
    check("d50_sync_a_high", na1, 75);
    check("d50_sync_b_first", nb1, 0);
    check("d50_sync_a_second", na2, 0);
    check("d50_sync_b_low", nb2, 75);
    wait_until(s0 + 162);
    check("d50_bit0_h1", {d50_a, d50_b}, 2'b10);
    wait_until(s0 + 187);
    check("d50_bit0_h2", {d50_a, d50_b}, 2'b01);
    wait_until(s0 + 212);
    check("d50_bit1_h1", {d50_a, d50_b}, 2'b01);
    @(posedge clk); #1 d50_en = 0;
    c1 = cyc;
    wait_until(c1 + 1);
    check("d50_disable", {d50_off, d50_a, d50_b, d50_active}, 4'b1000);

    // nominal frame at HALF=10
    @(posedge clk); #1;
    acc0 = n_acc; lim = 50; snap_r = n_rdy; snap_c = n_compl; snap_u = n_under; feed = 1;
    find_start(t0, ok);
    check("nom_start", ok, 1);
    s0 = t0 + 1;
    na1 = 0; nb1 = 0; na2 = 0; nb2 = 0;
    for (int c = 0; c < 6 * H; c++) begin
      wait_until(s0 + c);
      if (c == 0) check("nom_first_cycle", {active, off, a, b}, 4'b1010);
      if (c < 3 * H) begin na1 += int'(a); nb1 += int'(b); end
      else begin na2 += int'(a); nb2 += int'(b); end
    end
    check("nom_sync_hi", {na1[15:0], nb1[15:0]}, {16'(3 * H), 16'd0});
    check("nom_sync_lo", {na2[15:0], nb2[15:0]}, {16'd0, 16'(3 * H)});
    bad = 0;
    for (int w = 0; w < 50; w++) begin
      got = '0;
      for (int j = 0; j < 32; j++) begin
        wait_until(s0 + H * (6 + 2 * (w * 32 + j)) + H / 2);
        s_a1 = a; s_b1 = b;
        wait_until(s0 + H * (7 + 2 * (w * 32 + j)) + H / 2);
        s_a2 = a; s_b2 = b;
        got[j] = s_a1;
        if (!(s_a1 != s_b1 && s_a2 == s_b1 && s_b2 == s_a1)) bad++;
      end
      check($sformatf("nom_word%0d", w), got, 32'hA5A5_0000 + 32'(w));
    end
    check("nom_manchester_errors", bad, 0);
    wait_until(s0 + 3206 * H - 1);
    check("nom_before_end", {compl, active}, 2'b01);
    wait_until(s0 + 3206 * H);
    check("nom_end", {compl, active, ready, under, off}, 5'b10000);
    check("nom_accepts", n_acc - acc0, 50);
    check("nom_ready_cycles", n_rdy - snap_r, 50);
    wait_until(s0 + 3214 * H - 1);
    check("nom_gap_off", {off, a, b}, 3'b000);
    wait_until(s0 + 3214 * H);
    check("nom_off_release", off, 1);
    check("nom_compl_count", n_compl - snap_c, 1);
    check("nom_under_count", n_under - snap_u, 0);
    check("nom_duration", compl_cyc - s0, 32060);
    @(posedge clk); #1 feed = 0;

    // underrun after ten words
    @(posedge clk); #1;
    acc0 = n_acc; lim = 10; snap_c = n_compl; snap_u = n_under; feed = 1;
    find_start(t0, ok);
    check("und_start", ok, 1);
    s0 = t0 + 1;
    wait_until(s0 + 646 * H - 1);
    check("und_before", {under, active}, 2'b01);
    wait_until(s0 + 646 * H);
    check("und_pulse", {under, active, compl}, 3'b100);
    wait_until(s0 + 654 * H - 1);
    check("und_gap_off", off, 0);
    wait_until(s0 + 654 * H);
    check("und_off_release", off, 1);
    check("und_counts", {16'(n_under - snap_u), 16'(n_compl - snap_c)}, {16'd1, 16'd0});
    check("und_accepts", n_acc - acc0, 10);
    @(posedge clk); #1 feed = 0;

    // disable at bit 800
    @(posedge clk); #1;
    acc0 = n_acc; lim = 50; snap_c = n_compl; snap_u = n_under; feed = 1;
    find_start(t0, ok);
    check("dis_start", ok, 1);
    s0 = t0 + 1;
    wait_until(s0 + 1606 * H);
    @(posedge clk); #1 en = 0; feed = 0;
    c1 = cyc;
    wait_until(c1);
    check("dis_still_tx", {off, active}, 2'b01);
    wait_until(c1 + 1);
    check("dis_idle", {a, b, off, active, ready}, 5'b00100);
    wait_until(c1 + 4 * H);
    check("dis_no_pulses", {16'(n_compl - snap_c), 16'(n_under - snap_u)}, 32'd0);
    @(posedge clk); #1;
    acc0 = n_acc; lim = 50; en = 1; feed = 1;
    find_start(t0, ok);
    check("re_start", ok, 1);
    s0 = t0 + 1;
    wait_until(s0);
    check("re_first_cycle", {active, off, a, b}, 4'b1010);
    wait_until(s0 + 3 * H);
    check("re_sync_low", {a, b}, 2'b01);

    // asynchronous reset during DATA
    wait_until(s0 + 6 * H + 5);
    #2 reset = 0; feed = 0;
    #1 check("rst_async", {ready, active, compl, under, a, b, off}, 7'b0000001);
    @(posedge clk); @(posedge clk); #1 reset = 1;
    @(negedge clk);
    check("rst_idle_ready", {ready, active, off}, 3'b101);
    check("rst_no_pulses", {16'(n_compl - snap_c), 16'(n_under - snap_u)}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
